// File: rtl/ev22_regfile_rd2w1_pkg.sv
// EV22 register file shared definitions: widths, special register indices
// and the writable-index helper used by the write decoder and the bypass logic.
package ev22_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_GPR = 28;
    localparam int SEL_A_W = 5;
    localparam int SEL_W   = 6;
    localparam int GPR_AW  = $clog2(NUM_GPR);

    localparam logic [SEL_W-1:0] GPR_LIMIT = SEL_W'(NUM_GPR);
    localparam logic [SEL_W-1:0] PI0_IDX   = SEL_W'(28);
    localparam logic [SEL_W-1:0] PI1_IDX   = SEL_W'(29);
    localparam logic [SEL_W-1:0] PO0_IDX   = SEL_W'(30);
    localparam logic [SEL_W-1:0] PO1_IDX   = SEL_W'(31);
    localparam logic [SEL_W-1:0] WREG_IDX  = SEL_W'(34);

    // Input-port indices are read-only; everything outside the map is illegal.
    function automatic logic is_writable(input logic [SEL_W-1:0] idx);
        return (idx < GPR_LIMIT) || (idx == PO0_IDX) || (idx == PO1_IDX) || (idx == WREG_IDX);
    endfunction

endpackage

// File: rtl/ev22_regfile_rd2w1_if.sv
// Bus bundle between the EV22 core (master) and its register file (slave).
interface ev22_regfile_rd2w1_if;
    import ev22_pkg::*;

    logic              Rd_En;
    logic [SEL_A_W-1:0] Sel_A;
    logic [SEL_W-1:0]  Sel_B;
    logic              Wr_En;
    logic [SEL_W-1:0]  Wr_Sel;
    logic [DATA_W-1:0] Wr_Data;
    logic [DATA_W-1:0] Port_In_0;
    logic [DATA_W-1:0] Port_In_1;
    logic [DATA_W-1:0] Data_A;
    logic [DATA_W-1:0] Data_B;
    logic              Rd_Valid;
    logic [DATA_W-1:0] Port_Out_0;
    logic [DATA_W-1:0] Port_Out_1;
    logic              Sel_Err;

    modport master (
        output Rd_En, Sel_A, Sel_B, Wr_En, Wr_Sel, Wr_Data, Port_In_0, Port_In_1,
        input  Data_A, Data_B, Rd_Valid, Port_Out_0, Port_Out_1, Sel_Err
    );

    modport slave (
        input  Rd_En, Sel_A, Sel_B, Wr_En, Wr_Sel, Wr_Data, Port_In_0, Port_In_1,
        output Data_A, Data_B, Rd_Valid, Port_Out_0, Port_Out_1, Sel_Err
    );

endinterface

// File: rtl/ev22_regfile_rd2w1_sync2.sv
// Two-flop synchroniser for a bus sampled from outside the clock domain.
module ev22_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    // Two register stages give metastability time before the value is used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/ev22_regfile_rd2w1.sv
// EV22 register file: 28 GPRs, working register, two output-port registers,
// two synchronised input ports, two registered read ports and one write port
// with write-first bypass and illegal-index flagging.
module ev22_regfile_rd2w1
    import ev22_pkg::*;
(
    input logic                  Clk,
    input logic                  Reset_n,
    ev22_regfile_rd2w1_if.slave  bus
);

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] wreg;
    logic [DATA_W-1:0] po0;
    logic [DATA_W-1:0] po1;
    logic [DATA_W-1:0] pi0_sync;
    logic [DATA_W-1:0] pi1_sync;

    logic [SEL_W-1:0]  a_idx;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic              a_err;
    logic              b_err;
    logic              wr_ok;
    logic              wr_err;
    logic              byp_a;
    logic              byp_b;

    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              rd_valid;
    logic              sel_err;

    ev22_sync2 #(.WIDTH(DATA_W)) u_sync_pi0 (
        .clk     (Clk),
        .reset_n (Reset_n),
        .d       (bus.Port_In_0),
        .q       (pi0_sync)
    );

    ev22_sync2 #(.WIDTH(DATA_W)) u_sync_pi1 (
        .clk     (Clk),
        .reset_n (Reset_n),
        .d       (bus.Port_In_1),
        .q       (pi1_sync)
    );

    assign a_idx  = SEL_W'(bus.Sel_A);
    assign wr_ok  = bus.Wr_En && is_writable(bus.Wr_Sel);
    assign wr_err = bus.Wr_En && !is_writable(bus.Wr_Sel);
    assign byp_a  = wr_ok && (bus.Wr_Sel == a_idx);
    assign byp_b  = wr_ok && (bus.Wr_Sel == bus.Sel_B);

    // Storage update; a write coinciding with reset is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            gpr  <= '{default: '0};
            wreg <= '0;
            po0  <= '0;
            po1  <= '0;
        end else if (wr_ok) begin
            if (bus.Wr_Sel < GPR_LIMIT) begin
                gpr[bus.Wr_Sel[GPR_AW-1:0]] <= bus.Wr_Data;
            end else if (bus.Wr_Sel == PO0_IDX) begin
                po0 <= bus.Wr_Data;
            end else if (bus.Wr_Sel == PO1_IDX) begin
                po1 <= bus.Wr_Data;
            end else begin
                wreg <= bus.Wr_Data;
            end
        end
    end

    // Port A read mux; the working register is not reachable from A.
    always_comb begin
        a_val = '0;
        a_err = 1'b0;
        if (a_idx < GPR_LIMIT) begin
            a_val = gpr[a_idx[GPR_AW-1:0]];
        end else begin
            case (a_idx)
                PI0_IDX: a_val = pi0_sync;
                PI1_IDX: a_val = pi1_sync;
                PO0_IDX: a_val = po0;
                PO1_IDX: a_val = po1;
                default: a_err = 1'b1;
            endcase
        end
    end

    // Port B read mux, including the working register.
    always_comb begin
        b_val = '0;
        b_err = 1'b0;
        if (bus.Sel_B < GPR_LIMIT) begin
            b_val = gpr[bus.Sel_B[GPR_AW-1:0]];
        end else begin
            case (bus.Sel_B)
                PI0_IDX:  b_val = pi0_sync;
                PI1_IDX:  b_val = pi1_sync;
                PO0_IDX:  b_val = po0;
                PO1_IDX:  b_val = po1;
                WREG_IDX: b_val = wreg;
                default:  b_err = 1'b1;
            endcase
        end
    end

    // Registered operand outputs with write-first bypass and error pulse.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            data_a   <= '0;
            data_b   <= '0;
            rd_valid <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            rd_valid <= bus.Rd_En;
            sel_err  <= wr_err || (bus.Rd_En && (a_err || b_err));
            if (bus.Rd_En) begin
                data_a <= byp_a ? bus.Wr_Data : a_val;
                data_b <= byp_b ? bus.Wr_Data : b_val;
            end
        end
    end

    assign bus.Data_A     = data_a;
    assign bus.Data_B     = data_b;
    assign bus.Rd_Valid   = rd_valid;
    assign bus.Sel_Err    = sel_err;
    assign bus.Port_Out_0 = po0;
    assign bus.Port_Out_1 = po1;

endmodule
